// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and default line parameters
package uart_pkg;

    localparam int DEFAULT_CLK_FREQ  = 50_000_000;
    localparam int DEFAULT_BAUD_RATE = 1_000_000;
    localparam int DATA_BITS         = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - two-flop synchronizer, both stages reset to the idle-high level
module uart_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receive stage with valid/ready byte port
module uart_receiver
    import uart_pkg::*;
#(
    parameter int clk_freq    = DEFAULT_CLK_FREQ,
    parameter int baud_rate   = DEFAULT_BAUD_RATE,
    parameter int div_counter = clk_freq / baud_rate,
    parameter int half_div    = div_counter / 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] RxData,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_error,
    output logic                 overrun,
    output logic                 busy
);

    localparam int              CNT_W     = $clog2(div_counter);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(div_counter - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(half_div - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

    rx_state_t            state;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           bit_index;
    logic [DATA_BITS-1:0] shift;
    logic                 armed;
    logic [1:0]           fill;
    logic                 rx_s;

    uart_sync u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (RxD),
        .q     (rx_s)
    );

    assign busy = (state != IDLE);

    // The synchronizer's reset-to-1 contents are not evidence of an idle line,
    // so arming waits until fill shows both stages carry real RxD samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_index   <= '0;
            shift       <= '0;
            armed       <= 1'b0;
            fill        <= 2'b00;
            RxData      <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            overrun     <= 1'b0;
            fill        <= {fill[0], 1'b1};
            if (fill[1] && rx_s)
                armed <= 1'b1;
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (armed && !rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state     <= DATA;
                            bit_index <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == DIV_LAST) begin
                        cnt              <= '0;
                        shift[bit_index] <= rx_s;
                        if (bit_index == LAST_BIT)
                            state <= STOP;
                        else
                            bit_index <= bit_index + 3'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == DIV_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                        // A new byte may replace the held one only if it is leaving this cycle.
                        if (!rx_s) begin
                            frame_error <= 1'b1;
                        end else if (!rx_valid || rx_ready) begin
                            RxData   <= shift;
                            rx_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive stage and the downstream partner of the UART transmitter. It samples an asynchronous 8N1 serial line, recovers bytes at the mid-point of each bit, and presents them on a valid/ready byte port. It also flags framing errors and overruns. Both UART stages share the same clock, the same reset and the same baud parameters, so the transmitter's TxD can be looped directly into this block's RxD.

## Interface
- clk_freq, 50_000_000: system clock frequency in Hz.
- baud_rate, 1_000_000: line rate in bit/s.
- div_counter, clk_freq/baud_rate (50): clocks per bit. Must be ≥ 4.
- half_div, div_counter/2 (25): clocks from start-bit detection to the mid-start sample.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- RxD  in  1  serial line; idle high; asynchronous to clk.
- RxData  out  8  last accepted byte; reset 8'h00.
- rx_valid  out  1  RxData holds an unconsumed byte; reset 0.
- rx_ready  in  1  consumer accepts the byte this cycle when rx_valid=1.
- frame_error  out  1  one-cycle pulse when the stop bit samples low; reset 0.
- overrun  out  1  one-cycle pulse when a good byte is dropped; reset 0.
- busy  out  1  high whenever state ≠ IDLE; reset 0.

## Operation
- RxD passes through a 2-flop synchronizer (flops reset to 1) to produce rx_s. All decisions use rx_s.
- **Arming:**
  - After reset the receiver is disarmed and must see rx_s=1 for at least one cycle before it arms.
  - This prevents a line held low through reset from being taken as a start bit.
- **State machine** (rx_state_t):
  - IDLE: if armed and rx_s=0, go to START and clear the counter.
  - START: count to half_div-1, then sample rx_s.
    - rx_s=0: go to DATA; clear bit_index and the counter.
    - rx_s=1: glitch; return to IDLE with no output.
  - DATA: every div_counter cycles, write rx_s into shift[bit_index], LSB first.
    - After bit_index=7, go to STOP.
  - STOP: after div_counter cycles, sample rx_s, then go to IDLE.
    - rx_s=1: good frame.
    - rx_s=0: pulse frame_error, discard the byte, do not touch RxData or rx_valid.
- **Good frame delivery:**
  - rx_valid=0: load RxData and set rx_valid.
  - rx_valid=1 and rx_ready=1 in the same cycle: load the new byte; rx_valid stays 1.
  - rx_valid=1 and rx_ready=0: keep the old byte and pulse overrun; the new byte is lost.
- **Handshake:**
  - A transfer occurs on any cycle with rx_valid & rx_ready.
  - rx_valid clears on the next edge unless a new byte loads that same edge.
  - RxData is stable while rx_valid=1.
- **Counters:**
  - Cycle counter width is $clog2(div_counter); it wraps to 0 at each sample point.
  - bit_index is 3 bits.
- Returning to IDLE at mid-stop lets a following start bit be detected with no dead time.

## Timing
- Synchronizer latency is 2 clk from the RxD edge to rx_s.
- Counting from the first cycle rx_s=0 (cycle 0):
  - mid-start sample at cycle half_div;
  - data bit n sampled at half_div + (n+1)·div_counter;
  - stop sample at half_div + 9·div_counter.
- rx_valid, frame_error and overrun assert the cycle after the stop sample: 476 clk with defaults, 478 from the RxD edge.
- frame_error and overrun are exactly 1 cycle wide.
- busy rises 1 cycle after rx_s falls and drops in the same cycle rx_valid or frame_error asserts.
- **Reset mid-frame:**
  - All outputs and the state return to reset values immediately.
  - The partial byte is lost and the receiver is disarmed until rx_s=1 is seen.

## Structure
- Shared package uart_pkg holds:
  - typedef enum rx_state_t {IDLE, START, DATA, STOP};
  - the default clk_freq and baud_rate constants;
  - localparam DATA_BITS = 8.
- Sub-module uart_sync: a 2-flop synchronizer with asynchronous set to 1, used for RxD.
- The FSM, counters, shift register and output holding register live in uart_receiver.

## Test plan
- Loopback from the UART transmitter, sending 0xA5 with rx_ready=1 → RxData=0xA5, rx_valid high for 1 cycle, 478±1 clk after the start edge, frame_error=0.
- Back-to-back transmitted 0x00 then 0xFF with rx_ready=1 → two valid pulses exactly 10·div_counter (500) clk apart, data 0x00 then 0xFF, no overrun.
- 10-cycle low glitch on RxD → busy pulses, returns to IDLE by cycle half_div; no rx_valid and no frame_error.
- Frame 0x3C with the stop bit driven low → frame_error 1-cycle pulse; rx_valid stays 0; RxData unchanged.
- rx_ready=0 while receiving 0x11 then 0x22 → rx_valid stays high with RxData=0x11; overrun pulses once at the second stop sample; asserting rx_ready then drops rx_valid next cycle.
- reset asserted after the 4th data bit with RxD held low → all outputs 0 and busy=0; no start is detected until RxD goes high; the next full frame 0x5A is received correctly.
